// File: rtl/d_ff_pkg.sv
// Shared defaults for the D flip-flop register and its single-bit cell.
package d_ff_pkg;
  localparam int   D_FF_DEFAULT_WIDTH = 1;
  // One bit wide so instantiators can replicate it to any WIDTH.
  localparam logic D_FF_DEFAULT_RST   = '0;
endpackage

// File: rtl/d_ff_bit.sv
// Single-bit D cell: synchronous active-high reset to rst_val, capture gated by ce.
module d_ff_bit (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic ce,
  input  logic d,
  output logic q,
  output logic q_bar
);
  logic q_q, q_bar_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (ce) q_d = d;
  end

  // Both outputs are their own flops so they update on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q     <= rst_val;
      q_bar_q <= ~rst_val;
    end else begin
      q_q     <= q_d;
      q_bar_q <= ~q_d;
    end
  end

  assign q     = q_q;
  assign q_bar = q_bar_q;
endmodule

// File: rtl/d_flip_flop.sv
// WIDTH-bit D register with true/complement outputs built from d_ff_bit cells.
// Optional clock enable port ce is added when D_FF_CE_EN is defined.
module d_flip_flop
  import d_ff_pkg::*;
#(
  parameter int               WIDTH       = D_FF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{D_FF_DEFAULT_RST}}
) (
  input  logic             clk,
  input  logic             rst,
`ifdef D_FF_CE_EN
  input  logic             ce,
`endif
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);
  logic ce_w;

`ifdef D_FF_CE_EN
  assign ce_w = ce;
`else
  assign ce_w = 1'b1;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    d_ff_bit u_bit (
      .clk    (clk),
      .rst    (rst),
      .rst_val(RESET_VALUE[i]),
      .ce     (ce_w),
      .d      (D[i]),
      .q      (q[i]),
      .q_bar  (q_bar[i])
    );
  end
endmodule

// File: tb/tb_d_flip_flop.sv
// Scoreboard bench for d_flip_flop: a 1-bit instance and an 8-bit instance (reset 8'hA5).
module tb_d_flip_flop;
  typedef struct {
    logic       q1;
    logic [7:0] q8;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst1 = 1'b1, rst8 = 1'b1;
  logic       D1 = 1'b0;
  logic [7:0] D8 = 8'h00;
  logic       ce8 = 1'b1;
  logic       q1, qb1;
  logic [7:0] q8, qb8;

  exp_t exp_q[$];
  logic       m1;
  logic [7:0] m8;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  d_flip_flop #(.WIDTH(1)) u_dut1 (
    .clk  (clk),
    .rst  (rst1),
`ifdef D_FF_CE_EN
    .ce   (1'b1),
`endif
    .D    (D1),
    .q    (q1),
    .q_bar(qb1)
  );

  d_flip_flop #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_dut8 (
    .clk  (clk),
    .rst  (rst8),
`ifdef D_FF_CE_EN
    .ce   (ce8),
`endif
    .D    (D8),
    .q    (q8),
    .q_bar(qb8)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at t=%0t", name, act, expv, $time);
    end
  endtask

  // Issue one cycle of stimulus at the falling edge and push what the next rising edge must produce.
  // glitch toggles rst and D between edges and restores them before the edge.
  task automatic step(input logic r1, input logic d1, input logic r8, input logic [7:0] d8,
                      input logic c8, input logic glitch);
    exp_t e;
    logic ce_eff;
    @(negedge clk);
    if (glitch) begin
      rst1 = 1'b1; rst8 = 1'b1; D1 = ~d1; D8 = ~d8;
      #2;
    end
    rst1 = r1; D1 = d1; rst8 = r8; D8 = d8; ce8 = c8;
`ifdef D_FF_CE_EN
    ce_eff = c8;
`else
    ce_eff = 1'b1;
`endif
    m1 = r1 ? 1'b0 : d1;
    if (r8)          m8 = 8'hA5;
    else if (ce_eff) m8 = d8;
    e.q1 = m1;
    e.q8 = m8;
    exp_q.push_back(e);
  endtask

  // Monitor: one expectation per rising edge, sampled 1 ns after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("q1",     {7'b0, q1},  {7'b0, e.q1});
        chk("q_bar1", {7'b0, qb1}, {7'b0, ~e.q1});
        chk("q8",     q8,          e.q8);
        chk("q_bar8", qb8,         ~e.q8);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    step(1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);  // reset both
    step(1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0);  // q1 holds 0, q8 -> 3C
    step(1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);  // q1 -> 1, q8 holds when ce gated
    step(1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0);  // reset wins over D
    step(1'b0, 1'b1, 1'b0, 8'h77, 1'b1, 1'b0);  // capture resumes
    step(1'b0, 1'b1, 1'b0, 8'h77, 1'b1, 1'b1);  // rst/D glitch between edges ignored
    step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);  // reset wins over ce=0
    for (int i = 0; i < 80; i++) begin
      step(($urandom_range(7) == 0), 1'($urandom), ($urandom_range(7) == 0),
           8'($urandom), 1'($urandom), ($urandom_range(3) == 0));
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
